// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and a registered in_ready.
// Optional saturating stall/flush counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 12
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                in_ready_q,  in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   out_ctrl_q,  out_ctrl_d;
  logic [1:0]          occ_q,       occ_d;

  logic accept;
  logic emit;

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  // Next-state and payload steering; flush overrides every load.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (accept) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          state_d     = ST_FULL;
        end else if (emit) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush) begin
      state_d     = ST_EMPTY;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
    end
  end

  // Registered handshake/status outputs derived from the next state.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    out_ctrl_d  = out_valid_d ? main_ctrl_d : '0;
    case (state_d)
      ST_ONE:  occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign occupancy = occ_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: stalled-output cycles and flushes that killed live entries.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
